ring_sequence_checker: RTL
==========================

# ring_sequence_checker

Receive-side monitor for the one-hot ring counter bus. Samples a WIDTH-bit ring code, decodes it to a binary index, verifies that each valid sample is the one-step successor of the previous one (bit i → bit i+1, wrapping from bit WIDTH-1 to bit 0), and reports lock status and errors. It sits downstream of any ring counter instance and feeds status logic or a debug register block.

## Interface

- WIDTH, 4, ring code width; must be ≥ 2.
- LOCK_CNT, 2, consecutive correct successor transitions required to declare lock; must be ≥ 1.
- ERR_CNT_W, 8, width of the saturating error counter.

Ports:

- clk  input  1  clock; all state updates on rising edge.
- reset  input  1  reset, asynchronous, active-high; clock clk.
- in_valid  input  1  ring_in holds a new sample this cycle. The ring has advanced exactly one step since the previous valid sample.
- ring_in  input  WIDTH  ring code; bit 0 is index 0.
- clr_err  input  1  synchronous clear of err_count.
- idx_out  output  clog2(WIDTH)  index of the last legal sample; holds between samples.
- idx_valid  output  1  one-cycle pulse: idx_out was updated by a legal sample.
- locked  output  1  high while the FSM is in LOCKED.
- seq_err  output  1  one-cycle pulse: legal sample that was not the successor, while LOCKED.
- illegal  output  1  one-cycle pulse: valid sample with zero or more than one bit set, in any state.
- err_count  output  ERR_CNT_W  count of seq_err plus illegal-while-LOCKED events; saturates at all-ones.

## Operation

- Legal sample: in_valid=1 and exactly one bit of ring_in is set. Its index is the position of that bit. Successor of p is (p+1) mod WIDTH.
- Internal registers: state, prev (last legal index), good (0..LOCK_CNT).
- Cycles with in_valid=0 change nothing. Pulses deassert.
- SEARCH (reset state):
  - Legal sample: prev←idx, good←0, go to ACQUIRE.
  - Illegal sample: illegal pulse, stay in SEARCH.
- ACQUIRE:
  - Legal successor: prev←idx, good←good+1. When the new good equals LOCK_CNT, go to LOCKED.
  - Legal non-successor, including a repeat: prev←idx, good←0, stay in ACQUIRE.
  - Illegal sample: illegal pulse, go to SEARCH.
- LOCKED:
  - Legal successor: prev←idx, stay in LOCKED.
  - Legal non-successor, including a repeat: seq_err pulse, err_count+1, prev←idx, good←0, go to ACQUIRE.
  - Illegal sample: illegal pulse, err_count+1, go to SEARCH.
- Errors outside LOCKED never increment err_count.
- Every legal sample in any state updates idx_out and pulses idx_valid.
- err_count:
  - Saturates at 2^ERR_CNT_W−1.
  - clr_err sets it to 0. clr_err wins over a same-cycle increment.
- Reset (asynchronous, any time, including mid-LOCKED):
  - state=SEARCH, prev=0, good=0.
  - idx_out=0, idx_valid=0, locked=0, seq_err=0, illegal=0, err_count=0.

## Timing

- All outputs are registered and update on the rising edge that samples in_valid. They are visible one cycle after the sample is presented.
- locked rises on the edge that consumes the LOCK_CNT-th consecutive successor. It falls on the edge that consumes the first bad sample, coincident with the seq_err or illegal pulse.
- Minimum lock time from SEARCH: LOCK_CNT+1 valid samples.
- Back-to-back in_valid every cycle is fully supported, with no bubbles.
- Reset release: the first edge after deassertion may sample normally.

## Test plan

- WIDTH=4, LOCK_CNT=2. Samples 0001, 0010, 0100 on consecutive cycles → idx_out 0, 1, 2; idx_valid high each cycle; locked=1 after the third edge; err_count=0.
- While locked, continue 1000, 0001, 0010 → wrap accepted; locked stays 1; idx_out 3, 0, 1; no pulses.
- Locked at idx 1, sample 1000 → seq_err pulse, err_count=1, locked=0, idx_out=3. Then 0001, 0010 → relocks after the second sample.
- Locked, sample 0000, then 0110 → first sample: illegal pulse, err_count=1, locked=0, idx_out unchanged. Second sample: illegal pulse, err_count stays 1 (SEARCH).
- ERR_CNT_W=2. Force 5 lock/seq_err cycles → err_count saturates at 3. Assert clr_err on the same cycle as a seq_err → err_count=0.
- Assert reset mid-LOCKED with in_valid=1 → all outputs 0 immediately, without waiting for a clock edge. After release, 0100, 1000, 0001 → locked.

Source files
------------

// File: rtl/ring_sequence_checker.sv
// -----------------------------------------------------------------------------
// ring_sequence_checker
//
// Receive-side monitor for a one-hot ring counter bus. Each valid sample is
// decoded to a binary index. The checker confirms that it is the one-step
// successor of the previous legal sample, where bit i is followed by bit i+1
// and bit WIDTH-1 wraps to bit 0. It reports lock status and sequence or
// encoding errors, and keeps a saturating count of errors seen while locked.
//
// Parameters:
//   WIDTH      ring code width (>= 2)
//   LOCK_CNT   consecutive correct successors needed to declare lock (>= 1)
//   ERR_CNT_W  width of the saturating error counter
//
// Ports:
//   clk        in   1            clock, rising edge
//   reset      in   1            asynchronous, active-high reset
//   in_valid   in   1            ring_in carries a new sample this cycle
//   ring_in    in   WIDTH        one-hot ring code, bit 0 is index 0
//   clr_err    in   1            synchronous clear of err_count (wins over +1)
//   idx_out    out  clog2(WIDTH) index of the last legal sample (holds)
//   idx_valid  out  1            pulse: idx_out updated by a legal sample
//   locked     out  1            high while in LOCKED
//   seq_err    out  1            pulse: legal non-successor while LOCKED
//   illegal    out  1            pulse: valid sample not exactly one-hot
//   err_count  out  ERR_CNT_W    seq_err + illegal-while-LOCKED, saturating
// -----------------------------------------------------------------------------
module ring_sequence_checker #(
    parameter int WIDTH     = 4,
    parameter int LOCK_CNT  = 2,
    parameter int ERR_CNT_W = 8
) (
    input  logic                     clk,
    input  logic                     reset,
    input  logic                     in_valid,
    input  logic [WIDTH-1:0]         ring_in,
    input  logic                     clr_err,
    output logic [$clog2(WIDTH)-1:0] idx_out,
    output logic                     idx_valid,
    output logic                     locked,
    output logic                     seq_err,
    output logic                     illegal,
    output logic [ERR_CNT_W-1:0]     err_count
);

    localparam int IDX_W  = $clog2(WIDTH);
    localparam int GOOD_W = $clog2(LOCK_CNT + 1);

    localparam logic [1:0] ST_SEARCH  = 2'd0;
    localparam logic [1:0] ST_ACQUIRE = 2'd1;
    localparam logic [1:0] ST_LOCKED  = 2'd2;

    localparam logic [WIDTH-1:0]  RING_ONE  = {{(WIDTH-1){1'b0}}, 1'b1};
    localparam logic [IDX_W-1:0]  IDX_LAST  = IDX_W'(WIDTH - 1);
    localparam logic [IDX_W-1:0]  IDX_ONE   = IDX_W'(1);
    localparam logic [GOOD_W-1:0] GOOD_ONE  = GOOD_W'(1);
    localparam logic [GOOD_W-1:0] GOOD_LOCK = GOOD_W'(LOCK_CNT);
    localparam logic [ERR_CNT_W-1:0] ERR_ONE = ERR_CNT_W'(1);

    // ------------------------------------------------------------------
    // State registers
    // ------------------------------------------------------------------
    logic [1:0]           state_q,     state_d;
    logic [IDX_W-1:0]     prev_q,      prev_d;
    logic [GOOD_W-1:0]    good_q,      good_d;
    logic [IDX_W-1:0]     idx_q,       idx_d;
    logic                 idx_valid_q, idx_valid_d;
    logic                 seq_err_q,   seq_err_d;
    logic                 illegal_q,   illegal_d;
    logic [ERR_CNT_W-1:0] err_q,       err_d;

    // ------------------------------------------------------------------
    // Sample decode
    // ------------------------------------------------------------------
    logic             is_one_hot;
    logic             is_legal;
    logic [IDX_W-1:0] sample_idx;
    logic [IDX_W-1:0] succ_idx;
    logic             is_succ;
    logic [GOOD_W-1:0] good_inc;
    logic             err_inc;

    // Clearing the lowest set bit leaves zero only for a single-bit code.
    assign is_one_hot = (ring_in != '0) && ((ring_in & (ring_in - RING_ONE)) == '0);
    assign is_legal   = in_valid && is_one_hot;

    // Index of the set bit. When the code is not one-hot the value is
    // meaningless, but it is never used in that case.
    always_comb begin
        // NOTE: every signal written in always_comb gets a default first, so
        // no path through the block leaves it unassigned and infers a latch.
        sample_idx = '0;
        for (int i = 0; i < WIDTH; i++) begin
            if (ring_in[i]) begin
                sample_idx = IDX_W'(i);
            end
        end
    end

    // Explicit wrap so that non-power-of-two widths also work.
    assign succ_idx = (prev_q == IDX_LAST) ? '0 : (prev_q + IDX_ONE);
    assign is_succ  = (sample_idx == succ_idx);
    assign good_inc = good_q + GOOD_ONE;

    // ------------------------------------------------------------------
    // Next-state logic
    // ------------------------------------------------------------------
    always_comb begin
        state_d     = state_q;
        prev_d      = prev_q;
        good_d      = good_q;
        idx_d       = idx_q;
        idx_valid_d = 1'b0;
        seq_err_d   = 1'b0;
        illegal_d   = 1'b0;
        err_inc     = 1'b0;

        if (in_valid) begin
            if (is_legal) begin
                // Every legal sample is reported, whatever the state.
                idx_d       = sample_idx;
                idx_valid_d = 1'b1;
                prev_d      = sample_idx;

                case (state_q)
                    ST_SEARCH: begin
                        good_d  = '0;
                        state_d = ST_ACQUIRE;
                    end
                    ST_ACQUIRE: begin
                        if (is_succ) begin
                            good_d = good_inc;
                            if (good_inc == GOOD_LOCK) begin
                                state_d = ST_LOCKED;
                            end
                        end else begin
                            // A repeat or a jump restarts the run count.
                            good_d = '0;
                        end
                    end
                    ST_LOCKED: begin
                        if (!is_succ) begin
                            seq_err_d = 1'b1;
                            err_inc   = 1'b1;
                            good_d    = '0;
                            state_d   = ST_ACQUIRE;
                        end
                    end
                    default: begin
                        good_d  = '0;
                        state_d = ST_SEARCH;
                    end
                endcase
            end else begin
                // Zero or multiple bits set: reacquire from scratch. Only
                // errors that break an established lock are counted.
                illegal_d = 1'b1;
                state_d   = ST_SEARCH;
                if (state_q == ST_LOCKED) begin
                    err_inc = 1'b1;
                end
            end
        end
    end

    // Saturating error counter; a clear takes priority over an increment
    // in the same cycle.
    always_comb begin
        err_d = err_q;
        if (clr_err) begin
            err_d = '0;
        end else if (err_inc && !(&err_q)) begin
            err_d = err_q + ERR_ONE;
        end
    end

    // ------------------------------------------------------------------
    // Registers
    // ------------------------------------------------------------------
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state_q     <= ST_SEARCH;
            prev_q      <= '0;
            good_q      <= '0;
            idx_q       <= '0;
            idx_valid_q <= 1'b0;
            seq_err_q   <= 1'b0;
            illegal_q   <= 1'b0;
            err_q       <= '0;
        end else begin
            // NOTE: sequential state uses non-blocking assignments so every
            // flop samples the pre-edge value of every other flop.
            state_q     <= state_d;
            prev_q      <= prev_d;
            good_q      <= good_d;
            idx_q       <= idx_d;
            idx_valid_q <= idx_valid_d;
            seq_err_q   <= seq_err_d;
            illegal_q   <= illegal_d;
            err_q       <= err_d;
        end
    end

    // ------------------------------------------------------------------
    // Outputs
    // ------------------------------------------------------------------
    assign idx_out   = idx_q;
    assign idx_valid = idx_valid_q;
    assign locked    = (state_q == ST_LOCKED);
    assign seq_err   = seq_err_q;
    assign illegal   = illegal_q;
    assign err_count = err_q;

endmodule
